// File: rtl/addr_pkg.sv
// addr_pkg
//   Shared definitions for the sequential multi-byte adder.
//   - state_t   : controller states IDLE / ADD / DONE (2-bit encoding)
//   - BYTE_W    : width of one adder slice in bits
//   - idx_width : width of the byte index counter for a given byte count
package addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // A single-byte operand still needs a 1-bit index register.
  function automatic int idx_width(input int num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/simple_8bit_adder.sv
// simple_8bit_adder
//   Purely combinational 8-bit adder with carry in and carry out.
//   Ports:
//     a, b  in   8  addends
//     cin   in   1  carry in
//     sum   out  8  (a + b + cin) mod 256
//     cout  out  1  carry out of bit 7
module simple_8bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign sum  = full[7:0];
  assign cout = full[8];

endmodule

// File: rtl/multibyte_adder_seq.sv
// multibyte_adder_seq
//   Sequential W-bit adder (W = 8*NUM_BYTES) that pushes one byte per clock,
//   LSB first, through a single simple_8bit_adder, chaining the carry between
//   bytes. Operands arrive on a valid/ready handshake; the sum, carry-out and
//   two's-complement overflow flag leave on a second valid/ready handshake.
//   Ports:
//     clk        in   1  clock, rising edge
//     rst_n      in   1  asynchronous reset, active low
//     in_valid   in   1  operand set offered
//     in_ready   out  1  operand set can be taken (IDLE only, registered)
//     in_a       in   W  operand A
//     in_b       in   W  operand B
//     in_cin     in   1  carry into byte 0
//     out_valid  out  1  result available
//     out_ready  in   1  downstream takes result
//     out_sum    out  W  A + B + cin modulo 2^W
//     out_cout   out  1  carry out of the MSB byte
//     out_ovf    out  1  signed overflow of the W-bit add
//     busy       out  1  high in ADD or DONE
module multibyte_adder_seq
  import addr_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*NUM_BYTES-1:0]  in_a,
  input  logic [8*NUM_BYTES-1:0]  in_b,
  input  logic                    in_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NUM_BYTES-1:0]  out_sum,
  output logic                    out_cout,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;

  logic [BYTE_W-1:0] byte_sum;
  logic              byte_cout;
  logic [W-1:0]      sum_next;

  // Operands are shifted right one byte per ADD cycle, so the adder always
  // sees the current byte in the low slice; on the last byte that slice holds
  // the operand MSBs needed for the overflow flag.
  simple_8bit_adder u_adder (
    .a    (a_q[BYTE_W-1:0]),
    .b    (b_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (byte_sum),
    .cout (byte_cout)
  );

  // Result bytes enter at the top and shift down; after NUM_BYTES shifts the
  // first byte computed has reached bits [7:0].
  always_comb begin
    sum_next = sum_q >> BYTE_W;
    sum_next[W-1 -: BYTE_W] = byte_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry_q  <= in_cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end

        ADD: begin
          sum_q   <= sum_next;
          carry_q <= byte_cout;
          idx     <= idx + 1'b1;
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          if (idx == LAST_IDX) begin
            out_cout  <= byte_cout;
            out_ovf   <= (a_q[BYTE_W-1] == b_q[BYTE_W-1]) &&
                         (byte_sum[BYTE_W-1] != a_q[BYTE_W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // in_ready rises on the hand-off edge itself, so a waiting
          // upstream is accepted on the very next edge.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum = sum_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// tb_multibyte_adder_seq
//   Directed bench for multibyte_adder_seq: a 4-byte instance carries most of
//   the vectors, a 1-byte instance covers the single-byte latency case.
module tb_multibyte_adder_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  in_a1;
  logic [7:0]  in_b1;
  logic        in_cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  out_sum1;
  logic        out_cout1;
  logic        out_ovf1;
  logic        busy1;

  int total;
  int bad;

  multibyte_adder_seq #(.NUM_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  multibyte_adder_seq #(.NUM_BYTES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_cin    (in_cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_cout  (out_cout1),
    .out_ovf   (out_ovf1),
    .busy      (busy1)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer an operand set to the 4-byte instance and return just after the
  // accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checkOutput("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'hCAFE_F00D;
    in_cin   = 1'b1;
    checkOutput("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  // Count edges from the accept until out_valid, then check the result.
  task automatic waitResult(input string tag, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
    checkOutput({tag, "_sum"},  {32'd0, out_sum},  {32'd0, exp_sum});
    checkOutput({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
    checkOutput({tag, "_ovf"},  {63'd0, out_ovf},  {63'd0, exp_ovf});
  endtask

  // Complete the output handshake; in_ready must rise on the same edge.
  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_ready_rise"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int lat1;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_cin     = 1'b0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_a1      = '0;
    in_b1      = '0;
    in_cin1    = 1'b0;
    out_ready1 = 1'b0;

    // Reset values while rst_n is held low
    step();
    step();
    checkOutput("rst_in_ready",  {63'd0, in_ready},  64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_busy",      {63'd0, busy},      64'd0);
    checkOutput("rst_sum",       {32'd0, out_sum},   64'd0);
    checkOutput("rst_cout",      {63'd0, out_cout},  64'd0);
    checkOutput("rst_ovf",       {63'd0, out_ovf},   64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_no_ready", {63'd0, in_ready}, 64'd0);
    step();
    checkOutput("ready_first_edge",  {63'd0, in_ready},  64'd1);
    checkOutput("ready1_first_edge", {63'd0, in_ready1}, 64'd1);

    // 1: byte carry into byte 1
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
    waitResult("t1", 32'h0000_0100, 1'b0, 1'b0);
    takeResult("t1");

    // 2: carry-in ripples through every byte
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    waitResult("t2", 32'h0000_0000, 1'b1, 1'b0);
    takeResult("t2");

    // extra: all ones plus all ones plus carry, carry out without overflow
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitResult("t2b", 32'hFFFF_FFFF, 1'b1, 1'b0);
    takeResult("t2b");

    // 3: positive overflow
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    waitResult("t3", 32'h8000_0000, 1'b0, 1'b1);

    // 4: back-pressure with a second operand set waiting
    in_a     = 32'h0102_0304;
    in_b     = 32'h1020_3040;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("t4_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("t4_hold_sum",   {32'd0, out_sum},   {32'd0, 32'h8000_0000});
      checkOutput("t4_hold_ovf",   {63'd0, out_ovf},   64'd1);
      checkOutput("t4_hold_ready", {63'd0, in_ready},  64'd0);
    end
    takeResult("t4");
    applyStimulus(32'h0102_0304, 32'h1020_3040, 1'b1);
    waitResult("t4b", 32'h1122_3345, 1'b0, 1'b0);
    takeResult("t4b");

    // 5: asynchronous reset while idx == 2
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t5_rst_ready", {63'd0, in_ready},  64'd0);
    checkOutput("t5_rst_busy",  {63'd0, busy},      64'd0);
    checkOutput("t5_rst_sum",   {32'd0, out_sum},   64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_release_ready", {63'd0, in_ready}, 64'd0);
    step();
    checkOutput("t5_edge_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
    waitResult("t5", 32'h2345_6789, 1'b0, 1'b0);
    takeResult("t5");

    // 6: single-byte instance, latency 1
    in_a1     = 8'h80;
    in_b1     = 8'h80;
    in_cin1   = 1'b0;
    in_valid1 = 1'b1;
    checkOutput("t6_ready", {63'd0, in_ready1}, 64'd1);
    step();
    in_valid1 = 1'b0;
    lat1 = 0;
    while (!out_valid1 && lat1 < 20) begin
      step();
      lat1++;
    end
    checkOutput("t6_latency", 64'(lat1), 64'd1);
    checkOutput("t6_sum",  {56'd0, out_sum1},  64'd0);
    checkOutput("t6_cout", {63'd0, out_cout1}, 64'd1);
    checkOutput("t6_ovf",  {63'd0, out_ovf1},  64'd1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    checkOutput("t6_valid_drop", {63'd0, out_valid1}, 64'd0);
    checkOutput("t6_ready_rise", {63'd0, in_ready1},  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
